// File: rtl/cost_table_loader_if.sv
// Valid/ready stream carrying cost-table entries into cost_table_loader.
`timescale 1ns/1ps
interface cost_table_loader_if #(parameter int DW = 7);
  logic          In_valid;
  logic          In_ready;
  logic [DW-1:0] In_data;

  modport master (output In_valid, output In_data, input In_ready);
  modport slave  (input In_valid, input In_data, output In_ready);
endinterface

// File: rtl/cost_table_loader.sv
// Loads an NxN cost table from a stream, serves combinational lookups and
// accumulates the sum of row minima as a lower bound on the assignment cost.
//
// state | meaning
// IDLE  | just out of reset, moves to LOAD on the next edge
// LOAD  | accepting entries in row-major order
// READY | table complete and frozen, lookups valid
`timescale 1ns/1ps
module cost_table_loader #(
  parameter int DW = 7,
  parameter int N  = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  cost_table_loader_if.slave  in_if,
  input  logic                Clr,
  input  logic [2:0]          W,
  input  logic [2:0]          J,
  output logic [DW-1:0]       Cost,
  output logic                Table_ready,
  output logic [9:0]          LowerBound,
  output logic [6:0]          Load_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  localparam int LAST = N * N - 1;

  state_t        state_q, state_d;
  logic [DW-1:0] mem [N*N];
  logic [DW-1:0] row_min;
  logic [DW-1:0] entry_min;
  logic          in_ready;
  logic          hs;

  // Clr has priority over a handshake offered in the same cycle.
  assign hs        = in_if.In_valid & in_ready & ~Clr;
  assign entry_min = (in_if.In_data < row_min) ? in_if.In_data : row_min;
  assign in_if.In_ready = in_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = LOAD;
      LOAD:  if (!Clr && hs && Load_cnt == 7'(LAST)) state_d = READY;
      READY: if (Clr) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == LOAD);
    Table_ready = (state_q == READY);
    Cost        = Table_ready ? mem[{W, J}] : '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Load_cnt   <= '0;
      LowerBound <= '0;
      row_min    <= '0;
    end else if (Clr && state_q != IDLE) begin
      Load_cnt   <= '0;
      LowerBound <= '0;
      row_min    <= '0;
    end else if (hs) begin
      Load_cnt <= Load_cnt + 7'd1;
      if (Load_cnt[2:0] == 3'd0) row_min <= in_if.In_data;
      else                       row_min <= entry_min;
      if (Load_cnt[2:0] == 3'd7) LowerBound <= LowerBound + 10'(entry_min);
    end
  end

  // Table storage has no reset; Cost is gated until the table is complete.
  always_ff @(posedge CLK) begin
    if (hs) mem[Load_cnt[5:0]] <= in_if.In_data;
  end

endmodule

// File: tb/tb_cost_table_loader.sv
// Directed bench for cost_table_loader: loads, lookups, Clr and mid-load reset.
`timescale 1ns/1ps
module tb_cost_table_loader;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       Clr;
  logic [2:0] W, J;
  logic [6:0] Cost;
  logic       Table_ready;
  logic [9:0] LowerBound;
  logic [6:0] Load_cnt;

  int n_checks = 0;
  int n_errors = 0;

  cost_table_loader_if #(.DW(7)) in_if ();

  cost_table_loader #(.DW(7), .N(8)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .in_if       (in_if),
    .Clr         (Clr),
    .W           (W),
    .J           (J),
    .Cost        (Cost),
    .Table_ready (Table_ready),
    .LowerBound  (LowerBound),
    .Load_cnt    (Load_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int gen(input int pat, input int k);
    case (pat)
      0:       return (k * 5) % 100;
      1:       return 127;
      2:       return (k * 37 + 11) % 128;
      default: return 127 - ((k * 13) % 90);
    endcase
  endfunction

  function automatic int exp_lb(input int pat);
    int sum = 0;
    for (int r = 0; r < 8; r++) begin
      int m = gen(pat, 8 * r);
      for (int c = 1; c < 8; c++) if (gen(pat, 8 * r + c) < m) m = gen(pat, 8 * r + c);
      sum += m;
    end
    return sum;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input int d, input bit gaps);
    int guard = 0;
    if (gaps) begin
      for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
        in_if.In_valid = 1'b0;
        @(negedge CLK);
      end
    end
    in_if.In_valid = 1'b1;
    in_if.In_data  = 7'(d);
    while (!in_if.In_ready && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 100) check("ready_timeout", 0, 1);
    @(negedge CLK);
    in_if.In_valid = 1'b0;
  endtask

  task automatic load_table(input int pat, input bit gaps, input string tag);
    for (int k = 0; k < 63; k++) send(gen(pat, k), gaps);
    check({tag, "_ready_before_last"}, Table_ready, 0);
    check({tag, "_cnt_before_last"}, Load_cnt, 63);
    send(gen(pat, 63), gaps);
    check({tag, "_ready"}, Table_ready, 1);
    check({tag, "_cnt"}, Load_cnt, 64);
    check({tag, "_in_ready"}, in_if.In_ready, 0);
    check({tag, "_lb"}, LowerBound, exp_lb(pat));
  endtask

  task automatic sweep(input int pat, input string tag);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) begin
        W = 3'(w);
        J = 3'(j);
        #1;
        check($sformatf("%s_cost_w%0d_j%0d", tag, w, j), Cost, gen(pat, 8 * w + j));
      end
  endtask

  task automatic pulse_clr(input bit with_valid);
    Clr = 1'b1;
    in_if.In_valid = with_valid;
    in_if.In_data  = 7'd99;
    @(negedge CLK);
    Clr = 1'b0;
    in_if.In_valid = 1'b0;
    check("clr_cnt", Load_cnt, 0);
    check("clr_lb", LowerBound, 0);
    check("clr_table_ready", Table_ready, 0);
    check("clr_in_ready", in_if.In_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0;
    Clr = 1'b0;
    W = 3'd2;
    J = 3'd5;
    in_if.In_valid = 1'b0;
    in_if.In_data  = '0;
    #1;
    check("rst_in_ready", in_if.In_ready, 0);
    check("rst_table_ready", Table_ready, 0);
    check("rst_cnt", Load_cnt, 0);
    check("rst_lb", LowerBound, 0);
    check("rst_cost", Cost, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1 check("idle_in_ready", in_if.In_ready, 0);
    @(negedge CLK);
    check("load_in_ready", in_if.In_ready, 1);

    load_table(0, 1'b0, "b2b");
    sweep(0, "b2b");

    in_if.In_valid = 1'b1;
    in_if.In_data  = 7'd1;
    repeat (3) @(negedge CLK);
    in_if.In_valid = 1'b0;
    check("ready_ignore_cnt", Load_cnt, 64);
    check("ready_ignore_lb", LowerBound, exp_lb(0));
    sweep(0, "frozen");

    pulse_clr(1'b0);
    load_table(0, 1'b1, "gaps");
    sweep(0, "gaps");

    pulse_clr(1'b0);
    load_table(1, 1'b0, "max");
    check("max_lb_const", LowerBound, 1016);
    sweep(1, "max");

    pulse_clr(1'b0);
    for (int k = 0; k < 30; k++) send(gen(0, k), 1'b0);
    check("partial_cnt", Load_cnt, 30);
    pulse_clr(1'b1);
    load_table(2, 1'b0, "reload");
    sweep(2, "reload");

    pulse_clr(1'b0);
    for (int k = 0; k < 40; k++) send(gen(0, k), 1'b0);
    W = 3'd1;
    J = 3'd3;
    #2 RST_N = 1'b0;
    #1;
    check("midrst_in_ready", in_if.In_ready, 0);
    check("midrst_table_ready", Table_ready, 0);
    check("midrst_cost", Cost, 0);
    check("midrst_lb", LowerBound, 0);
    check("midrst_cnt", Load_cnt, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    load_table(3, 1'b0, "postrst");
    sweep(3, "postrst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cost_table_loader.md
# cost_table_loader

Upstream stage of the job-assignment engine. It accepts an 8x8 worker/job cost table as a 64-entry valid/ready stream and stores it in a register array. Once the table is complete, it serves the engine's combinational lookup: the engine drives W/J and samples Cost on the same edge. It also computes the sum of per-row minima (a lower bound on MinCost) while the table loads.

## Interface
Parameters:
- DW, 7, cost entry width (bits)
- N, 8, workers = jobs; table holds N*N entries

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  reset; one clock, asynchronous, active-low
- In_valid  input  1  In_data holds a valid entry
- In_ready  output  1  block can accept an entry this cycle
- In_data  input  DW  cost entry, row-major order: entry k is W=k/8, J=k%8
- Clr  input  1  single-cycle pulse; discard the table and restart loading
- W  input  3  worker index, from the engine
- J  input  3  job index, from the engine
- Cost  output  DW  table[W][J]; combinational
- Table_ready  output  1  all 64 entries are stored; lookups are valid
- LowerBound  output  10  sum over rows of the row minimum; valid while Table_ready=1
- Load_cnt  output  7  number of entries accepted so far (0..64)

## Operation
- States: IDLE, LOAD, READY.
  - IDLE: entered on reset; unconditionally goes to LOAD on the next edge.
  - LOAD: In_ready=1. A handshake (In_valid & In_ready) writes table[Load_cnt] and increments Load_cnt.
    - The 64th handshake moves the FSM to READY.
  - READY: In_ready=0; In_valid is ignored; the table is frozen.
    - Clr returns the FSM to LOAD, clears Load_cnt, LowerBound and the row-min register, and drops Table_ready.
- Clr in LOAD restarts the load: Load_cnt goes to 0 and any entry offered in the same cycle is discarded (Clr wins).
  - Table contents are not cleared; they are overwritten by the new load.
- Row minimum:
  - A 7-bit register row_min is loaded with the entry at J=0 and takes min(row_min, entry) for J=1..7.
  - At J=7 the completed minimum, min(row_min, In_data), is added into LowerBound.
- Arithmetic: LowerBound is 10 bits unsigned; the maximum is 8*127=1016, so there is no overflow.
- Cost = table[W][J] while Table_ready=1, and 0 otherwise.
  - It is a pure mux of the stored array; there is no register on the read path.
- Table_ready = (state==READY), registered.
- In_ready = (state==LOAD).

## Timing
- Reset values:
  - state IDLE.
  - In_ready 0, Table_ready 0, Load_cnt 0, LowerBound 0, Cost 0.
  - Table array is don't-care; Cost is forced to 0 while not ready.
- First cycle after RST_N rises: IDLE to LOAD, so In_ready=1 from the second edge onward.
- Accepting entries:
  - Maximum throughput is one entry per cycle.
  - With In_valid held high, a full load takes 64 cycles.
  - Table_ready rises on the edge that accepts entry 63.
  - LowerBound is final on that same edge.
- Lookup latency: 0 cycles. Cost changes in the same cycle as W/J, so the engine can accumulate on the next edge.
- Clr to LOAD takes one edge: In_ready=1 and Table_ready=0 in the following cycle.
- RST_N low at any point, mid-load or in READY, returns the block to IDLE immediately (asynchronously).
- In_valid without In_ready: no effect, no error. The upstream source holds the entry until the handshake occurs.

## Test plan
- Reset then load entry k = (k*5)%100 back-to-back:
  - Table_ready rises after exactly 64 accepts.
  - Load_cnt=64.
  - For each (W,J) in the 8x8 sweep, Cost equals ((8W+J)*5)%100.
  - LowerBound equals the sum of the 8 row minima.
- Load with In_valid toggling in a random 50% pattern:
  - Contents and LowerBound match the back-to-back load.
  - Entries offered while In_ready=0 after completion are ignored.
- All entries = 127:
  - LowerBound=1016.
  - Cost=127 for every (W,J).
- Clr pulsed after 30 entries, together with a valid entry, then a fresh 64-entry load:
  - Load_cnt=0 after the Clr edge.
  - The final table reflects only the second load.
- RST_N asserted mid-load (entry 40):
  - In_ready=0, Table_ready=0, Cost=0, LowerBound=0 immediately.
  - After RST_N is released, a full reload completes correctly.
- In READY, Clr then reload with a different table: Cost and LowerBound follow the new table.
